rotate_arbiter: RTL

//  Shares one rotate datapath between NREQ requesters. Each requester submits (data, amount, dir)

---
 rtl/rotate_pkg.sv | 22 ++
 rtl/rotate_arbiter_if.sv | 33 +++
 rtl/rot_core.sv | 28 ++
 rtl/rotate_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate arbiter: rotate-amount width helper,
// direction encodings and the request record used by command sources.
package rotate_pkg;

  // Width of a rotate amount for a W-bit operand.
  function automatic int rot_amt_w(input int w);
    return $clog2(w);
  endfunction

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  // Request record for the default 8-bit configuration.
  localparam int ROT_REQ_W = 8;

  typedef struct packed {
    logic [ROT_REQ_W-1:0]            data;
    logic [rot_amt_w(ROT_REQ_W)-1:0] amt;
    logic                            dir;
  } rot_req_t;

endpackage

// File: rtl/rotate_arbiter_if.sv
// Request/result bus between the command sources and the rotate arbiter.
// The master side drives requests and downstream ready; the slave side is
// the arbiter.
interface rotate_arbiter_if #(
  parameter int W    = 8,
  parameter int NREQ = 2
);
  import rotate_pkg::*;

  localparam int AW = rot_amt_w(W);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ*AW-1:0] req_amt;
  logic [NREQ-1:0]    req_dir;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [IW-1:0]      out_id;

  modport master (
    output req_valid, req_data, req_amt, req_dir, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/rot_core.sv
// Purely combinational W-bit rotator. Right rotation takes bit i from
// data[(i+amt) mod W], left rotation from data[(i-amt) mod W]. Because W is
// a power of two, index arithmetic on AW bits wraps modulo W by itself.
module rot_core
  import rotate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]            data,
  input  logic [rot_amt_w(W)-1:0] amt,
  input  logic                    dir,
  output logic [W-1:0]            res
);

  localparam int AW = rot_amt_w(W);

  // Select each result bit from its wrapped source position.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    res = '0;
    for (int i = 0; i < W; i++) begin
      if (dir == DIR_RIGHT) res[i] = data[AW'(i) + amt];
      else                  res[i] = data[AW'(i) - amt];
    end
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter in front of a single shared rotator. One request is
// granted per cycle when the single-entry output register can load; the
// rotated result and the winner's index are registered for downstream.
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  rotate_arbiter_if.slave  bus
);

  localparam int AW = rot_amt_w(W);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   r_rr_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [IW-1:0]   r_out_id;

  logic            w_can_load;
  logic            w_grant_any;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_grant;
  logic [W-1:0]    w_sel_data;
  logic [AW-1:0]   w_sel_amt;
  logic            w_sel_dir;
  logic [W-1:0]    w_res;

  // (base + off) mod NREQ, computed one bit wider so a non-power-of-two
  // NREQ wraps correctly; base and off are both below NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int            off);
    logic [IW:0] sum;
    sum = {1'b0, base} + (IW+1)'(off);
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    return sum[IW-1:0];
  endfunction

  // The output register can take a new result when empty or draining.
  assign w_can_load = !r_out_valid || bus.out_ready;

  // Priority scan starting at the round-robin pointer; no grant in reset.
  always_comb begin
    w_grant_any = 1'b0;
    w_win       = '0;
    w_grant     = '0;
    if (rst_n && w_can_load) begin
      for (int off = 0; off < NREQ; off++) begin
        if (!w_grant_any && bus.req_valid[wrap_idx(r_rr_ptr, off)]) begin
          w_grant_any = 1'b1;
          w_win       = wrap_idx(r_rr_ptr, off);
        end
      end
    end
    if (w_grant_any) w_grant[w_win] = 1'b1;
  end

  // Route the winner's operands to the shared rotator.
  always_comb begin
    w_sel_data = '0;
    w_sel_amt  = '0;
    w_sel_dir  = DIR_LEFT;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IW'(k)) begin
        w_sel_data = bus.req_data[k*W +: W];
        w_sel_amt  = bus.req_amt[k*AW +: AW];
        w_sel_dir  = bus.req_dir[k];
      end
    end
  end

  rot_core #(.W(W)) u_rot_core (
    .data (w_sel_data),
    .amt  (w_sel_amt),
    .dir  (w_sel_dir),
    .res  (w_res)
  );

  // Output register and round-robin pointer: load on grant, clear on drain.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples values from before this edge, independent of statement order.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant_any) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_id    <= w_win;
      r_rr_ptr    <= wrap_idx(w_win, 1);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

endmodule
